maquina_preparo: RTL
====================

# maquina_preparo

Drink-preparation controller. It is the consuming end of the drink-selection machine's status/display interface. It watches the selector's 2-bit status and 4-bit drink code, and drives the selector's `Timer` input when the user idles too long. When it sees an accepted selection it latches the drink code and runs that drink's recipe as a timed sequence of dosing outputs, then reports completion. It sits between the selection FSM and the valve/doser drivers.

## Interface
- `T_AGUA`, default 8: cycles the water valve stays open.
- `T_CAFE`, default 4: cycles the coffee doser runs.
- `T_LEITE`, default 4: cycles the milk doser runs; cappuccino uses 2×`T_LEITE`.
- `T_CHA`, default 6: cycles the tea doser runs.
- `T_TIMEOUT`, default 20: idle cycles before a `TIMER` pulse is issued.
- `CLK` in 1: rising-edge clock.
- `RST_N` in 1: asynchronous active-low reset.
- `STATUS` in 2: selector status. 00 = analysing, 01 = selecting, 11 = chosen, 10 = not chosen.
- `BEBIDA` in 4: selector display code. 0001 = espresso, 0010 = café com leite, 0011 = chá, 0100 = cappuccino.
- `TIMER` out 1: one-cycle pulse to the selector's `Timer` input.
- `VALV_AGUA` out 1: water valve.
- `DOSE_CAFE` out 1: coffee doser.
- `DOSE_LEITE` out 1: milk doser.
- `DOSE_CHA` out 1: tea doser.
- `OCUPADO` out 1: high from capture until recipe end.
- `PRONTO` out 1: one-cycle pulse when the recipe completes.
- `ERRO` out 1: one-cycle pulse when the latched code is invalid or the selection was abandoned.

## Operation
- States:
  - `OCIOSO`: waiting; idle timeout runs here.
  - `CAPTURA`: latch `BEBIDA`, decode the recipe.
  - `AGUA`, `CAFE`, `LEITE`, `CHA`: timed recipe steps.
  - `FIM`: recipe done.
  - `AGUARDA`: wait for `STATUS` to leave 11 before re-arming.
- Edge detect: a capture triggers only when `STATUS` goes from non-11 to 11, sampled against a registered copy `status_q`. `status_q` resets to 11, so a selector already sitting in 11 at reset does not start a drink.
- Idle timeout in `OCIOSO`:
  - The counter runs while `STATUS` is 00 or 01.
  - It clears when `BEBIDA` changes or `STATUS` is 10/11.
  - When it reaches `T_TIMEOUT`-1, `TIMER` pulses for one cycle and the counter clears.
- `OCIOSO` with `STATUS`=10 newly entered: `ERRO` pulses, then go to `AGUARDA`.
- Recipes. Each step runs exactly its parameter in cycles; exactly one dosing output is high per step.
  - 0001: `AGUA` → `CAFE`.
  - 0010: `AGUA` → `CAFE` → `LEITE`.
  - 0011: `AGUA` → `CHA`.
  - 0100: `CAFE` → `LEITE` (2×`T_LEITE`).
  - Any other code: `ERRO` pulse, go to `AGUARDA`, no dosing.
- `FIM`: `PRONTO` pulses, then go to `AGUARDA`.
- `AGUARDA`: go to `OCIOSO` once `STATUS` ≠ 11.
- Changes on `STATUS`/`BEBIDA` during a recipe are ignored; the recipe always completes.
- Step counter width: enough bits for max(2×`T_LEITE`, `T_AGUA`, `T_CHA`, `T_TIMEOUT`). It counts down from duration−1 to 0.

## Timing
- Reset (async, immediate): state `OCIOSO`, all counters 0, `status_q`=11. All outputs 0.
- All outputs are registered. Dosing outputs are decoded from the state register, so they are glitch-free.
- Latency:
  - Cycle N: `STATUS` edge to 11 is sampled.
  - Cycle N+1: `CAPTURA`, `OCUPADO`=1.
  - Cycle N+2: first dosing output high.
- Step handover: the last cycle of one step is followed directly by the first cycle of the next. No gap cycle, no overlap.
- `PRONTO` is asserted on the cycle after the last dosing cycle. `OCUPADO` falls on that same cycle.
- Reset asserted mid-recipe: all dosing outputs drop asynchronously. No `PRONTO`/`ERRO` is issued.

## Structure
- Shared package `maquina_pkg` holds:
  - Drink codes: `COD_EXP`, `COD_LEITE`, `COD_CHA`, `COD_CAPP`.
  - Status codes: `ST_ANALISE`, `ST_ESCOLHA`, `ST_ESCOLHEU`, `ST_NAO_ESCOLHEU`.
  - Preparation state encoding.
- The selector is updated to import the same constants.
- Sub-module `contador_passo`: loadable down-counter with a `zero` flag. It is instantiated twice, once for step timing and once for the idle timeout.

## Test plan
- Espresso, default parameters: `STATUS` 01→11 with `BEBIDA`=0001.
  - `VALV_AGUA` is high for 8 cycles starting 2 cycles after the edge.
  - `DOSE_CAFE` is then high for 4 cycles.
  - `PRONTO` pulses once; `OCUPADO` is high for 13 cycles.
- Cappuccino: `BEBIDA`=0100 at the edge.
  - No `VALV_AGUA`; `DOSE_CAFE` 4 cycles, then `DOSE_LEITE` 8 cycles.
  - Toggling `BEBIDA` to 0011 mid-recipe changes nothing.
- Idle timeout: hold `STATUS`=01, `BEBIDA` constant for 20 cycles.
  - `TIMER` pulses on cycle 20.
  - Changing `BEBIDA` at cycle 15 delays the pulse to cycle 35.
- Invalid code and abandon:
  - 11 edge with `BEBIDA`=0111 gives an `ERRO` pulse and no dosing.
  - `STATUS`→10 gives an `ERRO` pulse.
  - Holding 11 afterwards never restarts a recipe.
- Reset:
  - `RST_N` low during `LEITE` clears all outputs within the same cycle.
  - Releasing reset with `STATUS`=11 held produces no brew; a later 00→11 edge starts one.

Source files
------------

// File: rtl/maquina_pkg.sv
// Constants shared by the drink selector and the preparation controller.
// Holds the drink codes, the status codes and the preparation state encoding.
package maquina_pkg;

   localparam logic [3:0] COD_EXP   = 4'b0001;
   localparam logic [3:0] COD_LEITE = 4'b0010;
   localparam logic [3:0] COD_CHA   = 4'b0011;
   localparam logic [3:0] COD_CAPP  = 4'b0100;

   localparam logic [1:0] ST_ANALISE      = 2'b00;
   localparam logic [1:0] ST_ESCOLHA      = 2'b01;
   localparam logic [1:0] ST_ESCOLHEU     = 2'b11;
   localparam logic [1:0] ST_NAO_ESCOLHEU = 2'b10;

   typedef enum logic [2:0] {
      StOcioso,
      StCaptura,
      StAgua,
      StCafe,
      StLeite,
      StCha,
      StFim,
      StAguarda
   } prep_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/maquina_preparo_if.sv
// Status/display link from the selector plus the preparation controller outputs.
// The selector side (or a bench) uses master; the preparation controller uses slave.
interface maquina_preparo_if;

   logic [1:0] status;
   logic [3:0] bebida;
   logic       timer;
   logic       valv_agua;
   logic       dose_cafe;
   logic       dose_leite;
   logic       dose_cha;
   logic       ocupado;
   logic       pronto;
   logic       erro;

   modport master (
      output status,
      output bebida,
      input  timer,
      input  valv_agua,
      input  dose_cafe,
      input  dose_leite,
      input  dose_cha,
      input  ocupado,
      input  pronto,
      input  erro
   );

   modport slave (
      input  status,
      input  bebida,
      output timer,
      output valv_agua,
      output dose_cafe,
      output dose_leite,
      output dose_cha,
      output ocupado,
      output pronto,
      output erro
   );

endinterface

// File: rtl/contador_passo.sv
// Loadable down-counter with a zero flag; load wins over decrement.
// Decrementing stops at zero, so an idle counter simply parks there.
module contador_passo #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/maquina_preparo.sv
// Drink-preparation controller: captures an accepted selection, runs its timed
// dosing recipe, and pulses the selector's Timer input after a long idle spell.
module maquina_preparo
   import maquina_pkg::*;
#(
   parameter int unsigned T_AGUA    = 8,
   parameter int unsigned T_CAFE    = 4,
   parameter int unsigned T_LEITE   = 4,
   parameter int unsigned T_CHA     = 6,
   parameter int unsigned T_TIMEOUT = 20
) (
   input logic               clk_i,
   input logic               rst_ni,
   maquina_preparo_if.slave  bus
);

   localparam int unsigned MaxDur = max_u(max_u(2 * T_LEITE, T_AGUA),
                                          max_u(max_u(T_CHA, T_CAFE), T_TIMEOUT));
   localparam int unsigned CntW   = $clog2(MaxDur + 1);

   localparam logic [CntW-1:0] DurAgua  = CntW'(T_AGUA - 1);
   localparam logic [CntW-1:0] DurCafe  = CntW'(T_CAFE - 1);
   localparam logic [CntW-1:0] DurLeite = CntW'(T_LEITE - 1);
   localparam logic [CntW-1:0] DurCapp  = CntW'(2 * T_LEITE - 1);
   localparam logic [CntW-1:0] DurCha   = CntW'(T_CHA - 1);
   // The arming cycle counts as the first idle cycle, hence minus two.
   localparam logic [CntW-1:0] DurIdle  = CntW'(T_TIMEOUT - 2);

   prep_state_e     state_q, state_d;
   logic [1:0]      status_q;
   logic [3:0]      bebida_q, cod_q, cod_d;
   logic            erro_q, erro_d, timer_q, timer_d;
   logic            idle_arm_q, idle_arm_d;
   logic            step_load, step_dec, step_zero;
   logic [CntW-1:0] step_val;
   logic            idle_load, idle_dec, idle_zero;
   logic [CntW-1:0] idle_val;
   logic            escolheu_new, abandono_new, idle_run;

   assign escolheu_new = (bus.status == ST_ESCOLHEU) && (status_q != ST_ESCOLHEU);
   assign abandono_new = (bus.status == ST_NAO_ESCOLHEU) && (status_q != ST_NAO_ESCOLHEU);
   assign idle_run     = ((bus.status == ST_ANALISE) || (bus.status == ST_ESCOLHA)) &&
                         (bus.bebida == bebida_q);

   always_comb begin
      state_d    = state_q;
      cod_d      = cod_q;
      erro_d     = 1'b0;
      timer_d    = 1'b0;
      idle_arm_d = 1'b0;
      step_load  = 1'b0;
      step_val   = '0;
      step_dec   = 1'b0;
      // Idle counter is held cleared unless it is actively counting.
      idle_load  = 1'b1;
      idle_val   = '0;
      idle_dec   = 1'b0;

      unique case (state_q)
         StOcioso: begin
            if (escolheu_new) begin
               state_d = StCaptura;
               cod_d   = bus.bebida;
            end else if (abandono_new) begin
               erro_d  = 1'b1;
               state_d = StAguarda;
            end else if (idle_run) begin
               if (!idle_arm_q) begin
                  idle_val   = DurIdle;
                  idle_arm_d = 1'b1;
               end else if (idle_zero) begin
                  timer_d = 1'b1;
               end else begin
                  idle_load  = 1'b0;
                  idle_dec   = 1'b1;
                  idle_arm_d = 1'b1;
               end
            end
         end
         StCaptura: begin
            case (cod_q)
               COD_EXP, COD_LEITE, COD_CHA: begin
                  state_d   = StAgua;
                  step_load = 1'b1;
                  step_val  = DurAgua;
               end
               COD_CAPP: begin
                  state_d   = StCafe;
                  step_load = 1'b1;
                  step_val  = DurCafe;
               end
               default: begin
                  erro_d  = 1'b1;
                  state_d = StAguarda;
               end
            endcase
         end
         StAgua: begin
            if (!step_zero) begin
               step_dec = 1'b1;
            end else begin
               step_load = 1'b1;
               if (cod_q == COD_CHA) begin
                  state_d  = StCha;
                  step_val = DurCha;
               end else begin
                  state_d  = StCafe;
                  step_val = DurCafe;
               end
            end
         end
         StCafe: begin
            if (!step_zero) begin
               step_dec = 1'b1;
            end else if (cod_q == COD_EXP) begin
               state_d = StFim;
            end else begin
               state_d   = StLeite;
               step_load = 1'b1;
               step_val  = (cod_q == COD_CAPP) ? DurCapp : DurLeite;
            end
         end
         StLeite, StCha: begin
            if (!step_zero) begin
               step_dec = 1'b1;
            end else begin
               state_d = StFim;
            end
         end
         StFim: state_d = StAguarda;
         StAguarda: begin
            if (abandono_new) begin
               erro_d = 1'b1;
            end else if (bus.status != ST_ESCOLHEU) begin
               state_d = StOcioso;
            end
         end
         default: state_d = StOcioso;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StOcioso;
         status_q   <= ST_ESCOLHEU;
         bebida_q   <= '0;
         cod_q      <= '0;
         erro_q     <= 1'b0;
         timer_q    <= 1'b0;
         idle_arm_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         status_q   <= bus.status;
         bebida_q   <= bus.bebida;
         cod_q      <= cod_d;
         erro_q     <= erro_d;
         timer_q    <= timer_d;
         idle_arm_q <= idle_arm_d;
      end
   end

   contador_passo #(
      .Width (CntW)
   ) u_passo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (step_load),
      .load_val_i (step_val),
      .dec_i      (step_dec),
      .zero_o     (step_zero)
   );

   contador_passo #(
      .Width (CntW)
   ) u_ocioso (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (idle_load),
      .load_val_i (idle_val),
      .dec_i      (idle_dec),
      .zero_o     (idle_zero)
   );

   assign bus.valv_agua  = (state_q == StAgua);
   assign bus.dose_cafe  = (state_q == StCafe);
   assign bus.dose_leite = (state_q == StLeite);
   assign bus.dose_cha   = (state_q == StCha);
   assign bus.ocupado    = state_q inside {StCaptura, StAgua, StCafe, StLeite, StCha};
   assign bus.pronto     = (state_q == StFim);
   assign bus.erro       = erro_q;
   assign bus.timer      = timer_q;

endmodule
